// File: rtl/video_pkg.sv
// Shared constants, widths and state encoding for the video read scheduler.
package video_pkg;

   localparam int DEF_H_DISP     = 1920;
   localparam int DEF_V_DISP     = 1080;
   localparam int DEF_BURST_LEN  = 128;
   localparam int DEF_FIFO_DEPTH = 1024;
   localparam int DEF_ADDR_W     = 24;

   localparam int WORDS_W      = 22;
   localparam int RD_LEN_W     = 9;
   localparam int USEDW_W      = 11;
   localparam int FLUSH_CYCLES = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_CHECK,
      ST_REQ,
      ST_WAIT_DONE,
      ST_FEND
   } sched_state_t;

   // Length of the next burst: a full burst, or whatever is left of the frame.
   function automatic logic [RD_LEN_W-1:0] burst_words(
      input logic [WORDS_W-1:0] words_left,
      input int                 burst_len
   );
      if (words_left >= WORDS_W'(burst_len)) begin
         return RD_LEN_W'(burst_len);
      end
      return words_left[RD_LEN_W-1:0];
   endfunction

endpackage

// File: rtl/video_rd_sched_if.sv
// Burst request bus between the read scheduler and the SDRAM arbiter.
interface video_rd_sched_if
   import video_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);

   logic                rd_req;
   logic [ADDR_W-1:0]   rd_addr;
   logic [RD_LEN_W-1:0] rd_len;
   logic                rd_ack;
   logic                rd_done;

   modport master (
      output rd_req, rd_addr, rd_len,
      input  rd_ack, rd_done
   );

   modport slave (
      input  rd_req, rd_addr, rd_len,
      output rd_ack, rd_done
   );

endinterface

// File: rtl/video_rd_sched_vs_edge_det.sv
// Registered falling-edge detector on the active-low vertical sync.
module vs_edge_det (
   input  logic pixel_clk,
   input  logic sys_rst,
   input  logic video_vs,
   output logic frame_start
);

   logic vs_q;

   // Sync history clears in reset, so vsync held low across reset release is not an edge.
   always_ff @(posedge pixel_clk) begin
      if (sys_rst) begin
         vs_q <= 1'b0;
      end else begin
         vs_q <= video_vs;
      end
   end

   assign frame_start = vs_q & ~video_vs;

endmodule

// File: rtl/video_rd_sched.sv
// Frame read scheduler: flushes the pixel FIFO at frame start, then issues
// one SDRAM read burst at a time while the FIFO has room for a full burst.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | after reset, waiting for the first frame start
// FLUSH     | fifo_clr held for 4 cycles, frame base/word count loaded
// CHECK     | frame complete -> FEND, else wait for FIFO room
// REQ       | rd_req high with stable address/length until rd_ack
// WAIT_DONE | one burst outstanding, waiting for rd_done
// FEND      | frame fully fetched, waiting for the next frame start
module video_rd_sched
   import video_pkg::*;
#(
   parameter int H_DISP     = DEF_H_DISP,
   parameter int V_DISP     = DEF_V_DISP,
   parameter int BURST_LEN  = DEF_BURST_LEN,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int ADDR_W     = DEF_ADDR_W
) (
   input  logic               pixel_clk,
   input  logic               sys_rst,
   input  logic               video_vs,
   input  logic [1:0]         buf_idx,
   input  logic [USEDW_W-1:0] fifo_usedw,
   output logic               fifo_clr,
   output logic               frame_done,
   output logic               late_err,
   video_rd_sched_if.master   rd_bus
);

   localparam int                 FRAME_WORDS   = H_DISP * V_DISP;
   localparam logic [WORDS_W-1:0] FRAME_WORDS_W = WORDS_W'(FRAME_WORDS);
   localparam logic [ADDR_W-1:0]  FRAME_WORDS_A = ADDR_W'(FRAME_WORDS);
   localparam logic [USEDW_W-1:0] USEDW_MAX     = USEDW_W'(FIFO_DEPTH - BURST_LEN);

   sched_state_t        state;
   logic [1:0]          flush_cnt;
   logic [ADDR_W-1:0]   cur_addr;
   logic [WORDS_W-1:0]  words_left;
   logic                pend_sync;
   logic [1:0]          pend_idx;

   logic                frame_start;
   logic                ack_take;
   logic                enter_flush;
   logic [1:0]          flush_idx;
   logic [ADDR_W-1:0]   flush_base;
   logic [RD_LEN_W-1:0] next_len;

   vs_edge_det u_vs_edge_det (
      .pixel_clk   (pixel_clk),
      .sys_rst     (sys_rst),
      .video_vs    (video_vs),
      .frame_start (frame_start)
   );

   assign ack_take = rd_bus.rd_req & rd_bus.rd_ack;

   // A deferred restart uses the buffer index captured when its frame start happened,
   // unless a newer frame start arrives in the same cycle as rd_done.
   assign flush_idx  = frame_start ? buf_idx : pend_idx;
   assign flush_base = ADDR_W'(flush_idx) * FRAME_WORDS_A;
   assign next_len   = burst_words(words_left, BURST_LEN);

   // An accepted burst is never abandoned: restarts during it wait for rd_done.
   assign enter_flush = frame_start
      ? ((state inside {ST_IDLE, ST_CHECK, ST_FEND}) ||
         (state == ST_REQ && !ack_take) ||
         (state == ST_WAIT_DONE && rd_bus.rd_done))
      : (state == ST_WAIT_DONE && rd_bus.rd_done && pend_sync);

   // Scheduler state machine with registered outputs.
   always_ff @(posedge pixel_clk) begin
      if (sys_rst) begin
         state          <= ST_IDLE;
         flush_cnt      <= '0;
         cur_addr       <= '0;
         words_left     <= '0;
         pend_sync      <= 1'b0;
         pend_idx       <= '0;
         fifo_clr       <= 1'b0;
         frame_done     <= 1'b0;
         late_err       <= 1'b0;
         rd_bus.rd_req  <= 1'b0;
         rd_bus.rd_addr <= '0;
         rd_bus.rd_len  <= '0;
      end else begin
         frame_done <= 1'b0;
         late_err   <= 1'b0;

         if (frame_start) begin
            pend_idx <= buf_idx;
            if (state inside {ST_CHECK, ST_REQ, ST_WAIT_DONE}) begin
               late_err <= 1'b1;
            end
         end

         if (enter_flush) begin
            state         <= ST_FLUSH;
            fifo_clr      <= 1'b1;
            flush_cnt     <= 2'(FLUSH_CYCLES - 1);
            cur_addr      <= flush_base;
            words_left    <= FRAME_WORDS_W;
            pend_sync     <= 1'b0;
            rd_bus.rd_req <= 1'b0;
         end else begin
            case (state)
               ST_FLUSH: begin
                  if (flush_cnt == 2'd0) begin
                     fifo_clr <= 1'b0;
                     state    <= ST_CHECK;
                  end else begin
                     flush_cnt <= flush_cnt - 2'd1;
                  end
               end
               ST_CHECK: begin
                  if (words_left == '0) begin
                     frame_done <= 1'b1;
                     state      <= ST_FEND;
                  end else if (fifo_usedw <= USEDW_MAX) begin
                     rd_bus.rd_req  <= 1'b1;
                     rd_bus.rd_addr <= cur_addr;
                     rd_bus.rd_len  <= next_len;
                     state          <= ST_REQ;
                  end
               end
               ST_REQ: begin
                  if (ack_take) begin
                     rd_bus.rd_req <= 1'b0;
                     cur_addr      <= cur_addr + ADDR_W'(rd_bus.rd_len);
                     words_left    <= words_left - WORDS_W'(rd_bus.rd_len);
                     state         <= ST_WAIT_DONE;
                     if (frame_start) begin
                        pend_sync <= 1'b1;
                     end
                  end
               end
               ST_WAIT_DONE: begin
                  if (rd_bus.rd_done) begin
                     state <= ST_CHECK;
                  end else if (frame_start) begin
                     pend_sync <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_video_rd_sched.sv
// Directed bench for video_rd_sched: three instances cover the nominal frame,
// partial tail burst and FIFO backpressure configurations.
module tb_video_rd_sched;
   import video_pkg::*;

   logic        pixel_clk;
   logic        sys_rst;
   logic        vs_a, vs_b, vs_c;
   logic [1:0]  buf_idx;
   logic [10:0] usedw_a, usedw_b, usedw_c;
   logic        clr_a, clr_b, clr_c;
   logic        fd_a, fd_b, fd_c;
   logic        le_a, le_b, le_c;

   int n_checks;
   int n_errors;

   video_rd_sched_if #(.ADDR_W(24)) bus_a ();
   video_rd_sched_if #(.ADDR_W(24)) bus_b ();
   video_rd_sched_if #(.ADDR_W(24)) bus_c ();

   video_rd_sched #(.H_DISP(8), .V_DISP(4), .BURST_LEN(8), .FIFO_DEPTH(1024), .ADDR_W(24)) dut_a (
      .pixel_clk(pixel_clk), .sys_rst(sys_rst), .video_vs(vs_a), .buf_idx(buf_idx),
      .fifo_usedw(usedw_a), .fifo_clr(clr_a), .frame_done(fd_a), .late_err(le_a), .rd_bus(bus_a));

   video_rd_sched #(.H_DISP(10), .V_DISP(1), .BURST_LEN(8), .FIFO_DEPTH(1024), .ADDR_W(24)) dut_b (
      .pixel_clk(pixel_clk), .sys_rst(sys_rst), .video_vs(vs_b), .buf_idx(buf_idx),
      .fifo_usedw(usedw_b), .fifo_clr(clr_b), .frame_done(fd_b), .late_err(le_b), .rd_bus(bus_b));

   video_rd_sched #(.H_DISP(16), .V_DISP(16), .BURST_LEN(128), .FIFO_DEPTH(1024), .ADDR_W(24)) dut_c (
      .pixel_clk(pixel_clk), .sys_rst(sys_rst), .video_vs(vs_c), .buf_idx(buf_idx),
      .fifo_usedw(usedw_c), .fifo_clr(clr_c), .frame_done(fd_c), .late_err(le_c), .rd_bus(bus_c));

   initial begin
      pixel_clk = 1'b0;
      forever #5 pixel_clk = ~pixel_clk;
   end

   task automatic tick();
      @(posedge pixel_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      sys_rst = 1'b1;
      vs_a = 1'b1; vs_b = 1'b0; vs_c = 1'b1;
      buf_idx = 2'd1;
      usedw_a = 11'd0; usedw_b = 11'd0; usedw_c = 11'd1000;
      bus_a.rd_ack = 1'b0; bus_a.rd_done = 1'b0;
      bus_b.rd_ack = 1'b0; bus_b.rd_done = 1'b0;
      bus_c.rd_ack = 1'b0; bus_c.rd_done = 1'b0;

      // reset state
      repeat (3) tick();
      chk("rst_req", bus_a.rd_req, 0);
      chk("rst_addr", bus_a.rd_addr, 0);
      chk("rst_len", bus_a.rd_len, 0);
      chk("rst_clr", clr_a, 0);
      chk("rst_fdone", fd_a, 0);
      chk("rst_late", le_a, 0);

      // vsync held low through reset release is not a frame start
      sys_rst = 1'b0;
      repeat (4) begin
         tick();
         chk("vs_low_rel_clr", clr_b, 0);
         chk("vs_low_rel_late", le_b, 0);
      end

      // nominal frame: base 1*32, four bursts of 8
      vs_a = 1'b0; tick(); vs_a = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("a_flush_clr", clr_a, 1);
         chk("a_flush_noreq", bus_a.rd_req, 0);
         tick();
      end
      chk("a_flush_end", clr_a, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("a_req", bus_a.rd_req, 1);
         chk("a_addr", bus_a.rd_addr, 32 + 8 * k);
         chk("a_len", bus_a.rd_len, 8);
         tick();
         chk("a_req_hold", bus_a.rd_req, 1);
         chk("a_addr_hold", bus_a.rd_addr, 32 + 8 * k);
         bus_a.rd_ack = 1'b1; tick(); bus_a.rd_ack = 1'b0;
         chk("a_req_drop", bus_a.rd_req, 0);
         repeat (9) tick();
         chk("a_wait_noreq", bus_a.rd_req, 0);
         bus_a.rd_done = 1'b1; tick(); bus_a.rd_done = 1'b0;
         chk("a_fdone_early", fd_a, 0);
         tick();
      end
      chk("a_frame_done", fd_a, 1);
      chk("a_end_noreq", bus_a.rd_req, 0);
      chk("a_end_nolate", le_a, 0);
      tick();
      chk("a_frame_done_pulse", fd_a, 0);

      // frame start from FEND is not late; then a late start in WAIT_DONE
      buf_idx = 2'd2; vs_a = 1'b0; tick(); vs_a = 1'b1;
      chk("a2_fend_nolate", le_a, 0);
      chk("a2_clr", clr_a, 1);
      repeat (4) tick();
      chk("a2_clr_end", clr_a, 0);
      tick();
      chk("a2_addr", bus_a.rd_addr, 64);
      bus_a.rd_ack = 1'b1; tick(); bus_a.rd_ack = 1'b0;
      chk("a2_wait", bus_a.rd_req, 0);
      buf_idx = 2'd3; vs_a = 1'b0; tick(); vs_a = 1'b1; buf_idx = 2'd0;
      chk("a2_late", le_a, 1);
      chk("a2_noclr", clr_a, 0);
      tick();
      chk("a2_late_pulse", le_a, 0);
      repeat (3) begin
         chk("a2_noclr_wait", clr_a, 0);
         tick();
      end
      bus_a.rd_done = 1'b1; tick(); bus_a.rd_done = 1'b0;
      chk("a2_flush_after_done", clr_a, 1);
      chk("a2_no_second_late", le_a, 0);
      repeat (4) tick();
      chk("a2_flush_end", clr_a, 0);
      tick();
      chk("a2_new_base_req", bus_a.rd_req, 1);
      chk("a2_new_base_addr", bus_a.rd_addr, 96);

      // frame start in REQ without ack, then a stray ack during FLUSH
      vs_a = 1'b0; tick(); vs_a = 1'b1;
      chk("a3_req_drop", bus_a.rd_req, 0);
      chk("a3_late", le_a, 1);
      chk("a3_clr", clr_a, 1);
      bus_a.rd_ack = 1'b1; tick(); bus_a.rd_ack = 1'b0;
      chk("a3_stray_clr", clr_a, 1);
      chk("a3_stray_req", bus_a.rd_req, 0);
      chk("a3_late_pulse", le_a, 0);
      repeat (3) tick();
      chk("a3_flush_end", clr_a, 0);
      tick();
      chk("a3_req", bus_a.rd_req, 1);
      chk("a3_addr", bus_a.rd_addr, 0);
      chk("a3_len", bus_a.rd_len, 8);

      // partial tail: base 2*10, bursts of 8 then 2
      vs_b = 1'b1; tick();
      buf_idx = 2'd2; vs_b = 1'b0; tick(); vs_b = 1'b1;
      chk("b_clr", clr_b, 1);
      repeat (4) tick();
      chk("b_clr_end", clr_b, 0);
      tick();
      chk("b_req1", bus_b.rd_req, 1);
      chk("b_addr1", bus_b.rd_addr, 20);
      chk("b_len1", bus_b.rd_len, 8);
      bus_b.rd_ack = 1'b1; tick(); bus_b.rd_ack = 1'b0;
      bus_b.rd_done = 1'b1; tick(); bus_b.rd_done = 1'b0;
      tick();
      chk("b_req2", bus_b.rd_req, 1);
      chk("b_addr2", bus_b.rd_addr, 28);
      chk("b_len2", bus_b.rd_len, 2);
      bus_b.rd_ack = 1'b1; tick(); bus_b.rd_ack = 1'b0;
      bus_b.rd_done = 1'b1; tick(); bus_b.rd_done = 1'b0;
      chk("b_fdone_early", fd_b, 0);
      tick();
      chk("b_frame_done", fd_b, 1);
      chk("b_end_noreq", bus_b.rd_req, 0);
      tick();
      chk("b_frame_done_pulse", fd_b, 0);

      // frame start coinciding with rd_done goes straight to FLUSH
      buf_idx = 2'd1; vs_b = 1'b0; tick(); vs_b = 1'b1;
      repeat (4) tick();
      tick();
      chk("b2_addr", bus_b.rd_addr, 10);
      bus_b.rd_ack = 1'b1; tick(); bus_b.rd_ack = 1'b0;
      buf_idx = 2'd0; vs_b = 1'b0; bus_b.rd_done = 1'b1; tick();
      vs_b = 1'b1; bus_b.rd_done = 1'b0;
      chk("b2_coinc_clr", clr_b, 1);
      chk("b2_coinc_late", le_b, 1);
      tick();
      chk("b2_coinc_clr2", clr_b, 1);
      chk("b2_late_pulse", le_b, 0);
      repeat (3) tick();
      chk("b2_flush_end", clr_b, 0);
      tick();
      chk("b2_restart_addr", bus_b.rd_addr, 0);
      chk("b2_restart_len", bus_b.rd_len, 8);

      // backpressure: threshold 1024-128 = 896
      buf_idx = 2'd0; vs_c = 1'b0; tick(); vs_c = 1'b1;
      repeat (4) tick();
      repeat (6) begin
         tick();
         chk("c_full_noreq", bus_c.rd_req, 0);
      end
      usedw_c = 11'd897;
      repeat (3) begin
         tick();
         chk("c_897_noreq", bus_c.rd_req, 0);
      end
      usedw_c = 11'd896;
      tick();
      chk("c_896_req", bus_c.rd_req, 1);
      chk("c_addr", bus_c.rd_addr, 0);
      chk("c_len", bus_c.rd_len, 128);

      // reset during WAIT_DONE (and during REQ on instance c)
      bus_a.rd_ack = 1'b1; tick(); bus_a.rd_ack = 1'b0;
      bus_a.rd_done = 1'b1; tick(); bus_a.rd_done = 1'b0;
      tick();
      chk("a4_addr", bus_a.rd_addr, 8);
      bus_a.rd_ack = 1'b1; tick(); bus_a.rd_ack = 1'b0;
      sys_rst = 1'b1; tick();
      chk("a4_rst_req", bus_a.rd_req, 0);
      chk("a4_rst_addr", bus_a.rd_addr, 0);
      chk("a4_rst_len", bus_a.rd_len, 0);
      chk("a4_rst_clr", clr_a, 0);
      chk("a4_rst_fdone", fd_a, 0);
      chk("a4_rst_late", le_a, 0);
      chk("c_rst_req", bus_c.rd_req, 0);
      sys_rst = 1'b0; bus_a.rd_done = 1'b1; tick(); bus_a.rd_done = 1'b0;
      repeat (3) begin
         tick();
         chk("a4_idle_req", bus_a.rd_req, 0);
         chk("a4_idle_clr", clr_a, 0);
         chk("a4_idle_fdone", fd_a, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
